// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: ring-oscillator measurement sequencer.
// Debounces the up/down buttons into a wrap-around oscillator select, then runs
// each measurement as CLEAR -> SETTLE -> GATE -> DRAIN -> LATCH.
// Optional build macro AUTO_SCAN_EN adds scan_en_i, which continuously measures
// and walks the select through the bank.
module ro_measure_ctrl #(
  parameter int unsigned NUM_RO          = 16,
  parameter int unsigned SEL_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES   = 256,
  parameter int unsigned GATE_CYCLES     = 1000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_btn_i,
  input  logic             down_btn_i,
  input  logic             start_i,
`ifdef AUTO_SCAN_EN
  input  logic             scan_en_i,
`endif
  output logic [SEL_W-1:0] ro_sel_o,
  output logic             ro_en_o,
  output logic             cnt_clr_o,
  output logic             cnt_gate_o,
  input  logic [CNT_W-1:0] cnt_val_i,
  output logic [CNT_W-1:0] result_o,
  output logic [SEL_W-1:0] result_sel_o,
  output logic             result_valid_o,
  output logic             busy_o
);

  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SG_MAX  = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TMR_MAX = (SG_MAX > DRAIN_CYCLES) ? SG_MAX : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_GATE   = 3'd3,
    S_DRAIN  = 3'd4,
    S_LATCH  = 3'd5
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic              ro_en_q;
  logic              cnt_clr_q;
  logic              cnt_gate_q;
  logic              busy_q;
  logic              valid_q;
  logic [CNT_W-1:0]  result_q;
  logic [SEL_W-1:0]  result_sel_q;
  logic [SEL_W-1:0]  sel_q;

  logic              scan_c;
  logic              go_c;
  logic [1:0]        btn_raw_c;
  logic [1:0]        btn_evt_c;
  logic              up_c;
  logic              down_c;
  logic              sel_hold_c;

`ifdef AUTO_SCAN_EN
  assign scan_c = scan_en_i;
`else
  assign scan_c = 1'b0;
`endif

  assign go_c      = (state_q == S_IDLE) & (start_i | scan_c);
  assign btn_raw_c = {down_btn_i, up_btn_i};

  // Per-button synchronizer, debounce filter and press-event generator
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic            sync1_q;
    logic            sync2_q;
    logic            acc_q;
    logic            evt_q;
    logic [DB_W-1:0] cnt_q;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        acc_q   <= 1'b0;
        evt_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw_c[b];
        sync2_q <= sync1_q;
        evt_q   <= 1'b0;
        if (sync2_q != acc_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_q <= sync2_q;
            evt_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign btn_evt_c[b] = evt_q;
  end

  assign up_c       = btn_evt_c[0] & ~btn_evt_c[1];
  assign down_c     = btn_evt_c[1] & ~btn_evt_c[0];
  assign sel_hold_c = busy_q | go_c | scan_c;

  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_RO - 1)) ? '0 : s + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s);
    return (s == '0) ? SEL_W'(NUM_RO - 1) : s - SEL_W'(1);
  endfunction

  // Oscillator select: buttons when idle, auto-advance after each scan result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else if ((state_q == S_LATCH) && scan_c) begin
      sel_q <= sel_inc(sel_q);
    end else if (!sel_hold_c) begin
      if (up_c) begin
        sel_q <= sel_inc(sel_q);
      end else if (down_c) begin
        sel_q <= sel_dec(sel_q);
      end
    end
  end

  // Measurement sequencer; outputs are registered alongside the state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ro_en_q      <= 1'b0;
      cnt_clr_q    <= 1'b0;
      cnt_gate_q   <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      result_sel_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_c) begin
            state_q   <= S_CLEAR;
            ro_en_q   <= 1'b1;
            cnt_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q   <= S_SETTLE;
          cnt_clr_q <= 1'b0;
          timer_q   <= TMR_W'(SETTLE_CYCLES - 1);
        end
        S_SETTLE: begin
          if (timer_q == '0) begin
            state_q    <= S_GATE;
            cnt_gate_q <= 1'b1;
            timer_q    <= TMR_W'(GATE_CYCLES - 1);
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        S_GATE: begin
          if (timer_q == '0) begin
            state_q    <= S_DRAIN;
            cnt_gate_q <= 1'b0;
            timer_q    <= TMR_W'(DRAIN_CYCLES - 1);
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        S_DRAIN: begin
          if (timer_q == '0) begin
            state_q      <= S_LATCH;
            ro_en_q      <= 1'b0;
            result_q     <= cnt_val_i;
            result_sel_q <= sel_q;
            valid_q      <= 1'b1;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        S_LATCH: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          ro_en_q    <= 1'b0;
          cnt_clr_q  <= 1'b0;
          cnt_gate_q <= 1'b0;
          busy_q     <= 1'b0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ro_sel_o       = sel_q;
  assign ro_en_o        = ro_en_q;
  assign cnt_clr_o      = cnt_clr_q;
  assign cnt_gate_o     = cnt_gate_q;
  assign result_o       = result_q;
  assign result_sel_o   = result_sel_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed bench for ro_measure_ctrl with small timing parameters.
module tb_ro_measure_ctrl;

  localparam int unsigned NUM_RO   = 4;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned SETTLE   = 3;
  localparam int unsigned GATE     = 10;
  localparam int unsigned CNT_W    = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             up_btn;
  logic             down_btn;
  logic             start;
`ifdef AUTO_SCAN_EN
  logic             scan_en;
`endif
  logic [SEL_W-1:0] ro_sel;
  logic             ro_en;
  logic             cnt_clr;
  logic             cnt_gate;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] result;
  logic [SEL_W-1:0] result_sel;
  logic             result_valid;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ro_measure_ctrl #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .DEBOUNCE_CYCLES(DEBOUNCE),
    .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_btn_i(up_btn), .down_btn_i(down_btn),
    .start_i(start),
`ifdef AUTO_SCAN_EN
    .scan_en_i(scan_en),
`endif
    .ro_sel_o(ro_sel), .ro_en_o(ro_en), .cnt_clr_o(cnt_clr), .cnt_gate_o(cnt_gate),
    .cnt_val_i(cnt_val), .result_o(result), .result_sel_o(result_sel),
    .result_valid_o(result_valid), .busy_o(busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic u, input logic d);
    up_btn   = u;
    down_btn = d;
    step(10);
    up_btn   = 1'b0;
    down_btn = 1'b0;
    step(10);
  endtask

  initial begin
    int clr_cnt, gate_cnt, gate_first, en_cnt, busy_cnt, val_cnt, val_n, busy20;
    logic [CNT_W-1:0] got_res;
    logic [SEL_W-1:0] got_sel;
`ifdef AUTO_SCAN_EN
    int vt[5];
    logic [SEL_W-1:0] vs[5];
    int nv;
`endif

    rst_n    = 1'b0;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    start    = 1'b0;
    cnt_val  = 24'h001234;
`ifdef AUTO_SCAN_EN
    scan_en  = 1'b0;
`endif
    step(3);
    check("rst_outputs", {ro_en, cnt_clr, cnt_gate, result_valid, busy}, 32'h0);
    check("rst_sel", ro_sel, 32'h0);
    rst_n = 1'b1;
    step(2);
    check("idle_busy", busy, 32'h0);
    check("idle_result", result, 32'h0);

    // Short glitch shorter than the debounce window
    up_btn = 1'b1;
    step(3);
    up_btn = 1'b0;
    step(10);
    check("glitch_no_change", ro_sel, 32'h0);

    press(1'b1, 1'b0);
    check("up_1", ro_sel, 32'h1);
    press(1'b1, 1'b0);
    check("up_2", ro_sel, 32'h2);
    press(1'b1, 1'b0);
    check("up_3", ro_sel, 32'h3);
    press(1'b1, 1'b0);
    check("up_wrap", ro_sel, 32'h0);
    press(1'b0, 1'b1);
    check("down_wrap", ro_sel, 32'h3);
    press(1'b1, 1'b1);
    check("up_down_same", ro_sel, 32'h3);

    // Single measurement, sample n corresponds to cycle t+n
    clr_cnt = 0; gate_cnt = 0; gate_first = 0; en_cnt = 0; busy_cnt = 0;
    val_cnt = 0; val_n = 0; busy20 = 1; got_res = '0; got_sel = '0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      if (cnt_clr) clr_cnt++;
      if (cnt_gate) begin
        gate_cnt++;
        if (gate_first == 0) gate_first = n;
      end
      if (ro_en) en_cnt++;
      if (busy) busy_cnt++;
      if (n == 20) busy20 = busy;
      if (result_valid) begin
        val_cnt++;
        val_n   = n;
        got_res = result;
        got_sel = result_sel;
      end
      step(1);
    end
    check("clr_cycles", clr_cnt, 32'd1);
    check("gate_cycles", gate_cnt, 32'd10);
    check("gate_first", gate_first, 32'd5);
    check("ro_en_cycles", en_cnt, 32'd18);
    check("busy_cycles", busy_cnt, 32'd19);
    check("busy_after", busy20, 32'h0);
    check("valid_count", val_cnt, 32'd1);
    check("valid_cycle", val_n, 32'd19);
    check("result_val", got_res, 32'h001234);
    check("result_sel", got_sel, 32'h3);
    check("result_hold", result, 32'h001234);

    // Button press and start during GATE must be dropped
    cnt_val = 24'hABCDEF;
    val_cnt = 0; val_n = 0; busy_cnt = 0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      if (busy) busy_cnt++;
      if (result_valid) begin
        val_cnt++;
        val_n   = n;
        got_res = result;
        got_sel = result_sel;
      end
      if (n == 6) begin
        up_btn = 1'b1;
        start  = 1'b1;
      end
      if (n == 7) start = 1'b0;
      if (n == 16) up_btn = 1'b0;
      step(1);
    end
    check("drop_valid_count", val_cnt, 32'd1);
    check("drop_valid_cycle", val_n, 32'd19);
    check("drop_busy_cycles", busy_cnt, 32'd19);
    check("drop_sel", ro_sel, 32'h3);
    check("drop_result", got_res, 32'hABCDEF);
    check("drop_result_sel", got_sel, 32'h3);

    // Asynchronous reset in the middle of GATE
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    check("pre_rst_gate", cnt_gate, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en_gate", {ro_en, cnt_gate}, 32'h0);
    check("async_rst_busy", busy, 32'h0);
    check("async_rst_result", result, 32'h0);
    check("async_rst_sel", ro_sel, 32'h0);
    step(2);
    rst_n = 1'b1;
    val_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      if (result_valid) val_cnt++;
      if (busy) busy_cnt++;
      step(1);
    end
    check("post_rst_no_valid", val_cnt, 32'd0);
    check("post_rst_no_busy", busy_cnt, 32'd0);

`ifdef AUTO_SCAN_EN
    nv = 0;
    scan_en = 1'b1;
    for (int n = 1; n <= 115; n++) begin
      if (result_valid && nv < 5) begin
        vt[nv] = n;
        vs[nv] = result_sel;
        nv++;
      end
      step(1);
    end
    scan_en = 1'b0;
    step(30);
    check("scan_count", nv, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("scan_sel", vs[i], (i == 4) ? 32'h0 : 32'(i));
    end
    for (int i = 1; i < 5; i++) begin
      check("scan_spacing", vt[i] - vt[i-1], 32'd20);
    end
    check("scan_idle", busy, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
